// File: rtl/qpu_ifu_ifetch_pkg.sv
// ============================================================================
// Module      : qpu_ifu_ifetch_pkg
// Description : Shared widths, fetch FSM encoding and PC increment for the IFU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package qpu_ifu_ifetch_pkg;

    localparam int QPU_PC_SIZE    = 32;
    localparam int QPU_INSTR_SIZE = 32;
    localparam int QPU_XLEN       = 32;
    localparam int PC_INCR        = 4;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/qpu_ifu_ifetch.sv
// ============================================================================
// Module      : qpu_ifu_ifetch
// Description : IFU fetch controller: one-outstanding fetch, IR capture,
//               BPU-driven next PC, flush redirect and halt handling.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module qpu_ifu_ifetch
    import qpu_ifu_ifetch_pkg::*;
#(
    parameter int                  PC_SIZE    = QPU_PC_SIZE,
    parameter int                  INSTR_SIZE = QPU_INSTR_SIZE,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [PC_SIZE-1:0]    ifu_req_pc,
    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic [PC_SIZE-1:0]    bpu_pc,
    input  logic                  prdt_taken,
    input  logic [PC_SIZE-1:0]    prdt_pc_add_op1,
    input  logic [PC_SIZE-1:0]    prdt_pc_add_op2,
    output logic                  ifu_o_valid,
    input  logic                  ifu_o_ready,
    output logic [INSTR_SIZE-1:0] ifu_o_ir,
    output logic [PC_SIZE-1:0]    ifu_o_pc,
    output logic                  ifu_o_prdt_taken,
    input  logic                  pipe_flush_req,
    input  logic [PC_SIZE-1:0]    pipe_flush_pc,
    output logic                  pipe_flush_ack,
    input  logic                  halt_req,
    output logic                  halt_ack
);

    fetch_state_e          state_q, state_d;
    logic [PC_SIZE-1:0]    pc_q, pc_d;
    logic [PC_SIZE-1:0]    bpu_pc_q, bpu_pc_d;
    logic                  drop_q, drop_d;
    logic                  o_valid_q, o_valid_d;
    logic [INSTR_SIZE-1:0] ir_q, ir_d;
    logic [PC_SIZE-1:0]    o_pc_q, o_pc_d;
    logic                  o_prdt_q, o_prdt_d;

    logic                  req_hs;
    logic                  rsp_hs;
    logic                  capture;
    logic [PC_SIZE-1:0]    next_pc;

    // While a flushed request is still waiting for acceptance, the address
    // presented must not move, so it is parked in bpu_pc_q.
    assign ifu_req_valid  = rst_n & (state_q == ST_REQ) & ~halt_req;
    assign ifu_req_pc     = drop_q ? bpu_pc_q : pc_q;
    assign ifu_rsp_ready  = (state_q == ST_WAIT) & (drop_q | ~o_valid_q | ifu_o_ready);
    assign req_hs         = ifu_req_valid & ifu_req_ready;
    assign rsp_hs         = ifu_rsp_valid & ifu_rsp_ready;
    assign capture        = rsp_hs & ~drop_q & ~pipe_flush_req;
    assign next_pc        = prdt_taken ? (prdt_pc_add_op1 + prdt_pc_add_op2)
                                       : (bpu_pc_q + PC_SIZE'(PC_INCR));

    assign bpu_pc           = bpu_pc_q;
    assign pipe_flush_ack   = pipe_flush_req;
    assign halt_ack         = (state_q == ST_HALT);
    assign ifu_o_valid      = o_valid_q;
    assign ifu_o_ir         = ir_q;
    assign ifu_o_pc         = o_pc_q;
    assign ifu_o_prdt_taken = o_prdt_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        bpu_pc_d = bpu_pc_q;
        drop_d   = drop_q;
        case (state_q)
            ST_HALT: begin
                if (!halt_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    drop_d  = 1'b0;
                end else begin
                    if (pipe_flush_req && !drop_q) bpu_pc_d = pc_q;
                    if (req_hs) begin
                        bpu_pc_d = ifu_req_pc;
                        state_d  = ST_WAIT;
                    end
                    if (pipe_flush_req) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rsp_hs) begin
                    drop_d  = 1'b0;
                    state_d = halt_req ? ST_HALT : ST_REQ;
                    if (capture) pc_d = next_pc;
                end else if (pipe_flush_req) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_REQ;
        endcase
        // A redirect overrides any prediction-derived next PC.
        if (pipe_flush_req) pc_d = pipe_flush_pc;
    end

    always_comb begin
        o_valid_d = o_valid_q;
        ir_d      = ir_q;
        o_pc_d    = o_pc_q;
        o_prdt_d  = o_prdt_q;
        if (capture) begin
            ir_d     = ifu_rsp_instr;
            o_pc_d   = bpu_pc_q;
            o_prdt_d = prdt_taken;
        end
        if (pipe_flush_req)              o_valid_d = 1'b0;
        else if (capture)                o_valid_d = 1'b1;
        else if (o_valid_q && ifu_o_ready) o_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            bpu_pc_q  <= RESET_PC;
            drop_q    <= 1'b0;
            o_valid_q <= 1'b0;
            ir_q      <= '0;
            o_pc_q    <= '0;
            o_prdt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            bpu_pc_q  <= bpu_pc_d;
            drop_q    <= drop_d;
            o_valid_q <= o_valid_d;
            ir_q      <= ir_d;
            o_pc_q    <= o_pc_d;
            o_prdt_q  <= o_prdt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qpu_ifu_ifetch.sv
// ============================================================================
// Module      : tb_qpu_ifu_ifetch
// Description : Self-checking bench for qpu_ifu_ifetch with memory/BPU models.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_qpu_ifu_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr, bpu_pc;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
    logic        ifu_o_valid, ifu_o_ready;
    logic [31:0] ifu_o_ir, ifu_o_pc;
    logic        ifu_o_prdt_taken;
    logic        pipe_flush_req, pipe_flush_ack;
    logic [31:0] pipe_flush_pc;
    logic        halt_req, halt_ack;

    always #5 clk = ~clk;

    qpu_ifu_ifetch dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
        .bpu_pc(bpu_pc), .prdt_taken(prdt_taken),
        .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
        .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir),
        .ifu_o_pc(ifu_o_pc), .ifu_o_prdt_taken(ifu_o_prdt_taken),
        .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack),
        .halt_req(halt_req), .halt_ack(halt_ack)
    );

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Stimulus controls
    bit          rnd = 1'b0;
    bit          hold = 1'b0;
    bit          bpu_dir = 1'b0;
    bit          ordy_val = 1'b1;
    bit          halt_val = 1'b0;
    bit          flush_once = 1'b0;
    logic [31:0] flush_pc_val = 32'h0;

    // Memory model: one transaction, response held until consumed
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;
    logic [31:0] acc_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_busy = 1'b0;
        end else begin
            if (ifu_rsp_valid && ifu_rsp_ready) mem_busy = 1'b0;
            if (ifu_req_valid && ifu_req_ready) begin
                mem_busy = 1'b1;
                mem_addr = ifu_req_pc;
                mem_cnt  = rnd ? int'($urandom % 3) : 0;
                acc_q.push_back(ifu_req_pc);
            end
        end
    end

    // Reference model: the fetch engine described as "next address", "one
    // pending fetch", "discard pending result" and "halted".
    logic [31:0] m_fetch_pc, m_req_addr, m_out_addr, m_ir, m_ipc;
    bit          m_out, m_discard, m_halted, m_iv, m_ipt;
    bit          seen_p10_taken = 1'b0;

    always @(negedge clk) begin : p_cmp
        bit          e_req_v, e_rsp_r, req_hs, rsp_hs, cap, start_req;
        bit          was_halted, was_out;
        logic [31:0] new_pc;
        if (!rst_n) begin
            m_fetch_pc = 32'h0; m_req_addr = 32'h0; m_out_addr = 32'h0;
            m_ir = 32'h0; m_ipc = 32'h0; m_ipt = 1'b0;
            m_out = 1'b0; m_discard = 1'b0; m_halted = 1'b0; m_iv = 1'b0;
        end else begin
            e_req_v = !m_halted && !m_out && !halt_req;
            e_rsp_r = m_out && (m_discard || !m_iv || ifu_o_ready);
            chk("req_valid", {31'b0, ifu_req_valid}, {31'b0, e_req_v});
            if (e_req_v) chk("req_pc", ifu_req_pc, m_req_addr);
            chk("rsp_ready", {31'b0, ifu_rsp_ready}, {31'b0, e_rsp_r});
            if (m_out) chk("bpu_pc", bpu_pc, m_out_addr);
            chk("o_valid", {31'b0, ifu_o_valid}, {31'b0, m_iv});
            if (m_iv) begin
                chk("o_ir", ifu_o_ir, m_ir);
                chk("o_pc", ifu_o_pc, m_ipc);
                chk("o_prdt", {31'b0, ifu_o_prdt_taken}, {31'b0, m_ipt});
            end
            chk("halt_ack", {31'b0, halt_ack}, {31'b0, m_halted});
            chk("flush_ack", {31'b0, pipe_flush_ack}, {31'b0, pipe_flush_req});
            if (ifu_o_valid && ifu_o_pc == 32'h10 && ifu_o_prdt_taken) seen_p10_taken = 1'b1;

            req_hs     = e_req_v && ifu_req_ready;
            rsp_hs     = e_rsp_r && ifu_rsp_valid;
            cap        = rsp_hs && !m_discard && !pipe_flush_req;
            new_pc     = prdt_taken ? prdt_pc_add_op1 + prdt_pc_add_op2 : m_out_addr + 32'd4;
            was_halted = m_halted;
            was_out    = m_out;
            start_req  = 1'b0;

            if (pipe_flush_req)           m_iv = 1'b0;
            else if (cap)                 m_iv = 1'b1;
            else if (m_iv && ifu_o_ready) m_iv = 1'b0;
            if (cap) begin
                m_ir = ifu_rsp_instr; m_ipc = m_out_addr; m_ipt = prdt_taken;
            end

            if (was_halted) begin
                if (!halt_req) begin m_halted = 1'b0; start_req = 1'b1; end
            end else if (!was_out) begin
                if (halt_req) begin
                    m_halted = 1'b1; m_discard = 1'b0;
                end else if (req_hs) begin
                    m_out = 1'b1; m_out_addr = m_req_addr;
                    if (pipe_flush_req) m_discard = 1'b1;
                end else if (pipe_flush_req) begin
                    m_discard = 1'b1;
                end
            end else begin
                if (rsp_hs) begin
                    m_out = 1'b0; m_discard = 1'b0;
                    if (cap) m_fetch_pc = new_pc;
                    if (halt_req) m_halted = 1'b1;
                    else          start_req = 1'b1;
                end else if (pipe_flush_req) begin
                    m_discard = 1'b1;
                end
            end
            if (pipe_flush_req) m_fetch_pc = pipe_flush_pc;
            if (start_req) m_req_addr = m_fetch_pc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mem_busy && mem_cnt > 0) mem_cnt--;
        ifu_rsp_valid = mem_busy && (mem_cnt == 0) && !hold;
        ifu_rsp_instr = instr_of(mem_addr);
        if (rnd) begin
            ifu_req_ready   = ($urandom % 4) != 0;
            ifu_o_ready     = ($urandom % 10) < 7;
            pipe_flush_req  = ($urandom % 20) == 0;
            pipe_flush_pc   = $urandom & 32'h0000_FFFC;
            halt_req        = halt_req ? (($urandom % 4) != 0) : (($urandom % 40) == 0);
            prdt_taken      = ($urandom % 4) == 0;
            prdt_pc_add_op1 = $urandom;
            prdt_pc_add_op2 = $urandom;
        end else begin
            ifu_req_ready   = 1'b1;
            ifu_o_ready     = ordy_val;
            halt_req        = halt_val;
            pipe_flush_req  = flush_once;
            pipe_flush_pc   = flush_pc_val;
            flush_once      = 1'b0;
            prdt_taken      = bpu_dir && (bpu_pc == 32'h10);
            prdt_pc_add_op1 = 32'h10;
            prdt_pc_add_op2 = 32'hFFFF_FFF8;
        end
    endtask

    task automatic wait_acc(int n0, string nm);
        int k = 0;
        while (acc_q.size() <= n0 && k < 200) begin
            step();
            k++;
        end
        if (acc_q.size() <= n0) chk(nm, 32'h0, 32'h1);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_req_valid"}, {31'b0, ifu_req_valid}, 32'h0);
        chk({tag, "_o_valid"}, {31'b0, ifu_o_valid}, 32'h0);
        chk({tag, "_o_ir"}, ifu_o_ir, 32'h0);
        chk({tag, "_o_pc"}, ifu_o_pc, 32'h0);
        chk({tag, "_o_prdt"}, {31'b0, ifu_o_prdt_taken}, 32'h0);
        chk({tag, "_halt_ack"}, {31'b0, halt_ack}, 32'h0);
        chk({tag, "_rsp_ready"}, {31'b0, ifu_rsp_ready}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : p_main
        logic [31:0] exp_seq [9];
        logic [31:0] halted_pc;
        int          n0;
        int          k;
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10, 32'h8};

        rst_n = 1'b0;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = 32'h0;
        prdt_taken = 1'b0; prdt_pc_add_op1 = 32'h0; prdt_pc_add_op2 = 32'h0;
        ifu_o_ready = 1'b1; pipe_flush_req = 1'b0; pipe_flush_pc = 32'h0; halt_req = 1'b0;
        repeat (3) step();
        #1 check_reset_outputs("por");

        // Sequential fetch with a wrap-around taken prediction at 0x10
        bpu_dir = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, ifu_req_valid}, 32'h1);
        chk("first_req_pc", ifu_req_pc, 32'h0);
        k = 0;
        while (acc_q.size() < 9 && k < 100) begin step(); k++; end
        if (acc_q.size() < 9) chk("seq_timeout", 32'h0, 32'h1);
        else for (int i = 0; i < 9; i++) chk($sformatf("seq_pc%0d", i), acc_q[i], exp_seq[i]);
        step(); step();
        chk("taken_at_0x10", {31'b0, seen_p10_taken}, 32'h1);
        bpu_dir = 1'b0;

        // Flush while a fetch is outstanding
        hold = 1'b1;
        n0 = acc_q.size();
        wait_acc(n0, "flush_acc_timeout");
        flush_pc_val = 32'h200;
        flush_once = 1'b1;
        step();
        #1 chk("flush_ack_same_cycle", {31'b0, pipe_flush_ack}, 32'h1);
        hold = 1'b0;
        step();
        #1 chk("flush_o_valid", {31'b0, ifu_o_valid}, 32'h0);
        n0 = acc_q.size();
        wait_acc(n0, "post_flush_timeout");
        chk("post_flush_pc", acc_q[$], 32'h200);

        // Back-pressure from EXU holds the response
        ordy_val = 1'b0;
        k = 0;
        do begin step(); #1; k++; end while (!(ifu_o_valid && ifu_rsp_valid) && k < 50);
        chk("bp_rsp_ready_low", {31'b0, ifu_rsp_ready}, 32'h0);
        step(); step();
        #1 chk("bp_rsp_still_valid", {31'b0, ifu_rsp_valid}, 32'h1);
        ordy_val = 1'b1;
        step();
        #1 chk("bp_rsp_ready_release", {31'b0, ifu_rsp_ready}, 32'h1);

        // Halt while waiting for a response, then resume
        hold = 1'b1;
        n0 = acc_q.size();
        wait_acc(n0, "halt_acc_timeout");
        halted_pc = acc_q[$];
        halt_val = 1'b1;
        hold = 1'b0;
        k = 0;
        do begin step(); #1; k++; end while (!halt_ack && k < 20);
        chk("halt_ack", {31'b0, halt_ack}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            #1 chk("halt_no_req", {31'b0, ifu_req_valid}, 32'h0);
        end
        n0 = acc_q.size();
        halt_val = 1'b0;
        wait_acc(n0, "resume_timeout");
        chk("resume_pc", acc_q[$], halted_pc + 32'd4);

        // Reset asserted with a fetch outstanding
        hold = 1'b1;
        n0 = acc_q.size();
        wait_acc(n0, "rst_acc_timeout");
        step();
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        step(); step();
        hold = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("restart_req_valid", {31'b0, ifu_req_valid}, 32'h1);
        chk("restart_req_pc", ifu_req_pc, 32'h0);

        // Randomized traffic against the model
        rnd = 1'b1;
        repeat (3000) step();
        rnd = 1'b0;
        halt_val = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qpu_ifu_ifetch.md
Name: qpu_ifu_ifetch

Overview:
- IFU fetch controller for the QPU.
- Owns the fetch PC, issues one-outstanding fetch requests to instruction memory, and captures responses into the IR register that feeds decode/EXU.
- Drives the current-instruction PC to the lite BPU and consumes its prediction (prdt_taken, op1, op2) to form the next fetch PC.
- Services pipeline flush (redirect) and halt requests from the EXU.

Parameters:
- PC_SIZE, `QPU_PC_SIZE (32): fetch PC width.
- INSTR_SIZE, `QPU_INSTR_SIZE (32): instruction width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  memory accepts request.
- ifu_req_pc  out  PC_SIZE  fetch address.
- ifu_rsp_valid  in  1  fetch response valid.
- ifu_rsp_ready  out  1  IFU accepts response.
- ifu_rsp_instr  in  INSTR_SIZE  fetched instruction.
- bpu_pc  out  PC_SIZE  PC of the instruction currently on ifu_rsp_instr, to the lite BPU pc input.
- prdt_taken  in  1  BPU taken prediction for the response instruction.
- prdt_pc_add_op1  in  PC_SIZE  BPU adder operand 1.
- prdt_pc_add_op2  in  PC_SIZE  BPU adder operand 2.
- ifu_o_valid  out  1  IR holds a valid instruction.
- ifu_o_ready  in  1  EXU consumes IR.
- ifu_o_ir  out  INSTR_SIZE  instruction register.
- ifu_o_pc  out  PC_SIZE  PC of the IR instruction.
- ifu_o_prdt_taken  out  1  prediction recorded with the IR instruction.
- pipe_flush_req  in  1  redirect request from EXU.
- pipe_flush_pc  in  PC_SIZE  redirect target.
- pipe_flush_ack  out  1  redirect accepted.
- halt_req  in  1  stop fetching.
- halt_ack  out  1  fetch quiescent.

Behaviour:
- Reset values: ifu_req_valid=0, ifu_o_valid=0, ifu_o_ir=0, ifu_o_pc=0, ifu_o_prdt_taken=0, halt_ack=0, drop flag=0, pc_r=RESET_PC, state=REQ.
- Because the state after reset is REQ, the first request (pc=RESET_PC) is asserted in the first cycle after rst_n deasserts.
- States:
  - HALT: no requests; halt_ack=1.
  - REQ: ifu_req_valid=1, ifu_req_pc=pc_r.
  - WAIT: one request outstanding.
- REQ -> WAIT on ifu_req_valid & ifu_req_ready.
- Request stability: ifu_req_valid and ifu_req_pc stay stable until accepted. No withdrawal, even on flush.
- Response acceptance:
  - ifu_rsp_ready = (state==WAIT) & (drop | ~ifu_o_valid | ifu_o_ready).
  - Handshake = ifu_rsp_valid & ifu_rsp_ready.
  - bpu_pc = address of the outstanding request (registered at request accept).
- On a non-dropped response handshake:
  - IR <= ifu_rsp_instr, ifu_o_pc <= bpu_pc, ifu_o_prdt_taken <= prdt_taken, ifu_o_valid <= 1.
  - pc_r <= prdt_taken ? prdt_pc_add_op1+prdt_pc_add_op2 : bpu_pc+4. Addition is modulo 2^PC_SIZE; carry is discarded.
  - State -> REQ, or HALT if halt_req.
- IR drain: ifu_o_valid & ifu_o_ready with no new capture clears ifu_o_valid. Simultaneous drain and capture loads the new instruction (throughput 1 instruction per 2 cycles minimum).
- Flush:
  - pipe_flush_ack = pipe_flush_req (always accepted in the same cycle).
  - On flush: ifu_o_valid <= 0 and pc_r <= pipe_flush_pc.
  - Flush in WAIT, or in REQ before acceptance: set drop. The pending response is accepted and discarded, drop clears, and the next request is issued to pipe_flush_pc.
  - Flush coincident with a response handshake: the response is discarded and flush_pc wins.
  - Flush in HALT: pc_r updated only.
  - Flush has priority over BPU prediction in every case.
- Halt:
  - halt_req sampled in REQ before acceptance -> HALT immediately, with no request issued that cycle.
  - halt_req in WAIT -> HALT after the response, or after the dropped response completes.
  - halt_ack=1 only in HALT with no outstanding request.
  - Deasserting halt_req in HALT -> REQ at pc_r.
- Reset asserted mid-operation returns all registers to reset values asynchronously. Any in-flight response is not tracked; memory is reset alongside.

Decomposition:
- Shared defines (QPU_defines.v): QPU_PC_SIZE, QPU_INSTR_SIZE, QPU_XLEN, the state encodings (2-bit) and the sequential-PC increment constant (4).
- One natural sub-module: qpu_ifu_litebpu, instantiated externally beside the mini-decoder. This block keeps only the next-PC mux and adder internally, with no further sub-modules.

Test Plan:
- Reset release, ifu_req_ready=1, 1-cycle memory, prdt_taken=0 -> requests at 0x0, 0x4, 0x8. IR shows the instructions with ifu_o_pc 0x0/0x4/0x8.
- Response at pc 0x10 with prdt_taken=1, op1=0x10, op2=0xFFFFFFF8 -> next ifu_req_pc 0x8 (wrap-around add). ifu_o_prdt_taken=1.
- pipe_flush_req with pipe_flush_pc=0x200 while in WAIT -> ack same cycle, ifu_o_valid drops, response discarded, next request pc 0x200.
- ifu_o_ready=0 with IR full and a response pending -> ifu_rsp_ready=0 and the response is held. Raising ifu_o_ready captures it in the same cycle as the drain.
- halt_req during WAIT -> halt_ack=1 one cycle after the response. No further ifu_req_valid. Release -> fetch resumes at the expected next PC.
- rst_n asserted while in WAIT -> all outputs return to reset values immediately. Fetch restarts at RESET_PC.
